// File: rtl/rf_wb_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// rf_wb_ctrl_pkg
// Shared definitions for the register-file write-back controller:
//   - default register index / data widths
//   - index of the hard-wired zero register (x0)
//   - requester identifiers used by the round-robin pointer
// ---------------------------------------------------------------------------
package rf_wb_ctrl_pkg;

    localparam int RF_ADDR_WIDTH = 5;
    localparam int RF_DATA_WIDTH = 32;

    // x0 is hard-wired to zero: never written, never busy.
    localparam int RF_X0_IDX = 0;

    // Requester that wins the next contended cycle.
    typedef enum logic {
        REQ_EXU = 1'b0,
        REQ_LSU = 1'b1
    } req_id_e;

endpackage : rf_wb_ctrl_pkg

// File: rtl/rf_scoreboard.sv
// ---------------------------------------------------------------------------
// rf_scoreboard
// One busy bit per architectural register, used by the IDU for RAW stalls.
//   clk, rst             : clock, synchronous active-high reset (clears all)
//   set_en, set_addr     : issued instruction will write set_addr
//   clr_en, clr_addr     : register-file write in progress this cycle
//   chk_addr1/2          : source registers being checked
//   busy1/2              : registered busy bit of chk_addr1/2 (no bypass)
// ---------------------------------------------------------------------------
module rf_scoreboard
    import rf_wb_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH = RF_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  set_en,
    input  logic [ADDR_WIDTH-1:0] set_addr,
    input  logic                  clr_en,
    input  logic [ADDR_WIDTH-1:0] clr_addr,
    input  logic [ADDR_WIDTH-1:0] chk_addr1,
    input  logic [ADDR_WIDTH-1:0] chk_addr2,
    output logic                  busy1,
    output logic                  busy2
);

    localparam int NREG = 2 ** ADDR_WIDTH;

    logic [NREG-1:0] busy_q;
    logic [NREG-1:0] busy_d;

    generate
        for (genvar gi = 0; gi < NREG; gi++) begin : g_bit
            if (gi == RF_X0_IDX) begin : g_x0
                // x0 can never hold a pending write.
                assign busy_d[gi] = 1'b0;
            end else begin : g_reg
                logic set_hit;
                logic clr_hit;
                assign set_hit = set_en && (set_addr == ADDR_WIDTH'(gi));
                assign clr_hit = clr_en && (clr_addr == ADDR_WIDTH'(gi));
                // A same-cycle set belongs to a younger instruction, so it
                // overrides the clear of the older write.
                assign busy_d[gi] = set_hit | (busy_q[gi] & ~clr_hit);
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    // Bit 0 is constant 0, so checking x0 always reads not-busy.
    assign busy1 = busy_q[chk_addr1];
    assign busy2 = busy_q[chk_addr2];

endmodule : rf_scoreboard

// File: rtl/rf_wb_ctrl.sv
// ---------------------------------------------------------------------------
// rf_wb_ctrl
// Shares the register file's single write port between EXU and LSU with a
// round-robin arbiter, registers the winning write, and keeps the busy
// scoreboard used by the IDU for RAW hazard stalls.
//   clk, rst                        : clock, synchronous active-high reset
//   exu_valid/ready/waddr/wdata     : EXU write-back handshake
//   lsu_valid/ready/waddr/wdata     : LSU write-back handshake
//   set_en, set_addr                : IDU marks a destination register busy
//   chk_addr1/2, busy1/2            : IDU source-register busy lookup
//   rf_wen, rf_waddr, rf_wdata      : registered register-file write port
// ---------------------------------------------------------------------------
module rf_wb_ctrl
    import rf_wb_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH = RF_ADDR_WIDTH,
    parameter int DATA_WIDTH = RF_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  exu_valid,
    output logic                  exu_ready,
    input  logic [ADDR_WIDTH-1:0] exu_waddr,
    input  logic [DATA_WIDTH-1:0] exu_wdata,
    input  logic                  lsu_valid,
    output logic                  lsu_ready,
    input  logic [ADDR_WIDTH-1:0] lsu_waddr,
    input  logic [DATA_WIDTH-1:0] lsu_wdata,
    input  logic                  set_en,
    input  logic [ADDR_WIDTH-1:0] set_addr,
    input  logic [ADDR_WIDTH-1:0] chk_addr1,
    input  logic [ADDR_WIDTH-1:0] chk_addr2,
    output logic                  busy1,
    output logic                  busy2,
    output logic                  rf_wen,
    output logic [ADDR_WIDTH-1:0] rf_waddr,
    output logic [DATA_WIDTH-1:0] rf_wdata
);

    localparam logic [ADDR_WIDTH-1:0] X0_ADDR = ADDR_WIDTH'(RF_X0_IDX);

    req_id_e               rr_q;
    req_id_e               rr_d;
    logic                  grant_exu;
    logic                  grant_lsu;

    logic                  wen_q;
    logic                  wen_d;
    logic [ADDR_WIDTH-1:0] waddr_q;
    logic [ADDR_WIDTH-1:0] waddr_d;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [DATA_WIDTH-1:0] wdata_d;

    // -----------------------------------------------------------------------
    // Round-robin arbiter. The pointer only moves on a contended grant, so a
    // lone requester never steals the other side's next turn.
    // -----------------------------------------------------------------------
    always_comb begin
        grant_exu = 1'b0;
        grant_lsu = 1'b0;
        rr_d      = rr_q;
        if (!rst) begin
            if (exu_valid && lsu_valid) begin
                if (rr_q == REQ_EXU) begin
                    grant_exu = 1'b1;
                    rr_d      = REQ_LSU;
                end else begin
                    grant_lsu = 1'b1;
                    rr_d      = REQ_EXU;
                end
            end else if (exu_valid) begin
                grant_exu = 1'b1;
            end else if (lsu_valid) begin
                grant_lsu = 1'b1;
            end
        end
    end

    assign exu_ready = grant_exu;
    assign lsu_ready = grant_lsu;

    // -----------------------------------------------------------------------
    // Output register. An x0 write completes its handshake but never raises
    // the write enable; address/data hold when nothing is accepted.
    // -----------------------------------------------------------------------
    always_comb begin
        wen_d   = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        if (grant_exu) begin
            wen_d   = (exu_waddr != X0_ADDR);
            waddr_d = exu_waddr;
            wdata_d = exu_wdata;
        end else if (grant_lsu) begin
            wen_d   = (lsu_waddr != X0_ADDR);
            waddr_d = lsu_waddr;
            wdata_d = lsu_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_q    <= REQ_EXU;
            wen_q   <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
        end else begin
            rr_q    <= rr_d;
            wen_q   <= wen_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
        end
    end

    // Reset drops an in-flight write immediately rather than one cycle late.
    assign rf_wen   = wen_q & ~rst;
    assign rf_waddr = waddr_q;
    assign rf_wdata = wdata_q;

    rf_scoreboard #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_scoreboard (
        .clk       (clk),
        .rst       (rst),
        .set_en    (set_en),
        .set_addr  (set_addr),
        .clr_en    (wen_q),
        .clr_addr  (waddr_q),
        .chk_addr1 (chk_addr1),
        .chk_addr2 (chk_addr2),
        .busy1     (busy1),
        .busy2     (busy2)
    );

endmodule : rf_wb_ctrl

// File: tb/tb_rf_wb_ctrl.sv
// ---------------------------------------------------------------------------
// tb_rf_wb_ctrl
// Self-checking bench for rf_wb_ctrl: directed vector table, a reset-in-flight
// sequence, then randomized traffic checked against a behavioural model.
// ---------------------------------------------------------------------------
module tb_rf_wb_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        exu_valid, lsu_valid, set_en;
    logic        exu_ready, lsu_ready, busy1, busy2, rf_wen;
    logic [4:0]  exu_waddr, lsu_waddr, set_addr, chk_addr1, chk_addr2, rf_waddr;
    logic [31:0] exu_wdata, lsu_wdata, rf_wdata;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    rf_wb_ctrl #(
        .ADDR_WIDTH (5),
        .DATA_WIDTH (32)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .exu_valid (exu_valid),
        .exu_ready (exu_ready),
        .exu_waddr (exu_waddr),
        .exu_wdata (exu_wdata),
        .lsu_valid (lsu_valid),
        .lsu_ready (lsu_ready),
        .lsu_waddr (lsu_waddr),
        .lsu_wdata (lsu_wdata),
        .set_en    (set_en),
        .set_addr  (set_addr),
        .chk_addr1 (chk_addr1),
        .chk_addr2 (chk_addr2),
        .busy1     (busy1),
        .busy2     (busy2),
        .rf_wen    (rf_wen),
        .rf_waddr  (rf_waddr),
        .rf_wdata  (rf_wdata)
    );

    // One cycle of stimulus and its expected observations in that cycle.
    typedef struct {
        logic [31:0] rs, ev, ea, ed, lv, la, ld, se, sa, c1, c2;
        logic [31:0] er, lr, b1, b2, wen, wa, wd, cw;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        rst = 1'b0; exu_valid = 1'b0; lsu_valid = 1'b0; set_en = 1'b0;
        exu_waddr = '0; exu_wdata = '0; lsu_waddr = '0; lsu_wdata = '0;
        set_addr = '0; chk_addr1 = '0; chk_addr2 = '0;
    endtask

    task automatic add(input logic [31:0] rs, ev, ea, ed, lv, la, ld, se, sa, c1, c2,
                       input logic [31:0] er, lr, b1, b2, wen, wa, wd, cw);
        vec_t v;
        v.rs = rs; v.ev = ev; v.ea = ea; v.ed = ed; v.lv = lv; v.la = la; v.ld = ld;
        v.se = se; v.sa = sa; v.c1 = c1; v.c2 = c2;
        v.er = er; v.lr = lr; v.b1 = b1; v.b2 = b2; v.wen = wen; v.wa = wa; v.wd = wd; v.cw = cw;
        vecs.push_back(v);
    endtask

    // Randomized traffic against a behavioural model of the write-back rules.
    task automatic rand_phase(input int ncyc);
        bit          mb[32];
        int          pref;          // 0: EXU wins next contention, 1: LSU
        bit          mwen, known;
        logic [4:0]  mwa;
        logic [31:0] mwd;
        bit          exv, lsv, ger, glr;
        logic [4:0]  exa, lsa;
        logic [31:0] exd, lsd;
        int          ntx = 0;
        pref = 0; mwen = 0; known = 1; mwa = '0; mwd = '0;
        exv = 0; lsv = 0; exa = '0; lsa = '0; exd = '0; lsd = '0;
        for (int r = 0; r < 32; r++) mb[r] = 0;
        for (int c = 0; c < ncyc; c++) begin
            if (!exv && $urandom_range(0, 9) < 6) begin
                exv = 1; exa = 5'($urandom_range(0, 31)); exd = $urandom;
            end
            if (!lsv && $urandom_range(0, 9) < 5) begin
                lsv = 1; lsa = 5'($urandom_range(0, 31)); lsd = $urandom;
            end
            rst       = (c == 0) || ($urandom_range(0, 59) == 0);
            exu_valid = exv; exu_waddr = exa; exu_wdata = exd;
            lsu_valid = lsv; lsu_waddr = lsa; lsu_wdata = lsd;
            set_en    = ($urandom_range(0, 3) == 0);
            set_addr  = 5'($urandom_range(0, 31));
            if (set_en && set_addr != 0 && mb[set_addr] && !(mwen && mwa == set_addr))
                set_en = 1'b0;
            chk_addr1 = 5'($urandom_range(0, 31));
            chk_addr2 = 5'($urandom_range(0, 31));
            #1;
            assert (!(set_en && !rst && set_addr != 0 && mb[set_addr] && !(mwen && mwa == set_addr)))
                else $error("IDU protocol violation: set on busy x%0d", set_addr);
            ger = !rst && exv && (!lsv || pref == 0);
            glr = !rst && lsv && (!exv || pref == 1);
            if (c > 0) begin
                chk($sformatf("rnd%0d exu_ready", c), 32'(exu_ready), 32'(ger));
                chk($sformatf("rnd%0d lsu_ready", c), 32'(lsu_ready), 32'(glr));
                chk($sformatf("rnd%0d rf_wen", c), 32'(rf_wen), 32'(mwen && !rst));
                if (!rst) begin
                    chk($sformatf("rnd%0d busy1", c), 32'(busy1), 32'(mb[chk_addr1]));
                    chk($sformatf("rnd%0d busy2", c), 32'(busy2), 32'(mb[chk_addr2]));
                end
                if (known) begin
                    chk($sformatf("rnd%0d rf_waddr", c), 32'(rf_waddr), 32'(mwa));
                    chk($sformatf("rnd%0d rf_wdata", c), rf_wdata, mwd);
                end
            end
            // Advance the model across the clock edge.
            if (rst) begin
                for (int r = 0; r < 32; r++) mb[r] = 0;
                pref = 0; mwen = 0; mwa = '0; mwd = '0; known = 1;
            end else begin
                if (mwen) mb[mwa] = 0;
                if (set_en && set_addr != 0) mb[set_addr] = 1;
                if (exv && lsv) pref = 1 - pref;
                if (ger || glr) begin
                    mwa   = ger ? exa : lsa;
                    mwd   = ger ? exd : lsd;
                    mwen  = (mwa != 0);
                    known = mwen;
                    ntx++;
                    $display("txn %0d: cycle %0d %s writes x%0d <= 0x%08h", ntx, c,
                             ger ? "EXU" : "LSU", mwa, mwd);
                end else begin
                    mwen = 0;
                end
                if (ger) exv = 0;
                if (glr) lsv = 0;
            end
            tick();
        end
    endtask

    initial begin
        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;

        //   rs ev ea ed            lv la ld          se sa c1 c2 | er lr b1 b2 wen wa wd        cw
        add(0, 1, 5, 'h1234,       0, 0, 0,          0, 0, 5, 0,   1, 0, 0, 0, 0,  0, 0,        1);
        add(0, 0, 0, 0,            0, 0, 0,          0, 0, 0, 0,   0, 0, 0, 0, 1,  5, 'h1234,   1);
        add(0, 0, 0, 0,            0, 0, 0,          0, 0, 0, 0,   0, 0, 0, 0, 0,  5, 'h1234,   1);
        add(0, 1, 1, 'hA1,         1, 2, 'hB2,       0, 0, 0, 0,   1, 0, 0, 0, 0,  5, 'h1234,   1);
        add(0, 1, 3, 'hA3,         1, 2, 'hB2,       0, 0, 0, 0,   0, 1, 0, 0, 1,  1, 'hA1,     1);
        add(0, 1, 3, 'hA3,         1, 4, 'hB4,       0, 0, 0, 0,   1, 0, 0, 0, 1,  2, 'hB2,     1);
        add(0, 1, 6, 'hA6,         1, 4, 'hB4,       0, 0, 0, 0,   0, 1, 0, 0, 1,  3, 'hA3,     1);
        add(0, 1, 6, 'hA6,         0, 0, 0,          0, 0, 0, 0,   1, 0, 0, 0, 1,  4, 'hB4,     1);
        add(0, 0, 0, 0,            0, 0, 0,          0, 0, 0, 0,   0, 0, 0, 0, 1,  6, 'hA6,     1);
        add(0, 0, 0, 0,            0, 0, 0,          0, 0, 0, 0,   0, 0, 0, 0, 0,  6, 'hA6,     1);
        add(0, 0, 0, 0,            0, 0, 0,          1, 7, 7, 0,   0, 0, 0, 0, 0,  6, 'hA6,     1);
        add(0, 0, 0, 0,            0, 0, 0,          0, 0, 7, 0,   0, 0, 1, 0, 0,  6, 'hA6,     1);
        add(0, 0, 0, 0,            1, 7, 'h77,       0, 0, 7, 0,   0, 1, 1, 0, 0,  6, 'hA6,     1);
        add(0, 0, 0, 0,            0, 0, 0,          0, 0, 7, 0,   0, 0, 1, 0, 1,  7, 'h77,     1);
        add(0, 0, 0, 0,            0, 0, 0,          0, 0, 7, 0,   0, 0, 0, 0, 0,  7, 'h77,     1);
        add(0, 0, 0, 0,            0, 0, 0,          1, 3, 0, 3,   0, 0, 0, 0, 0,  7, 'h77,     1);
        add(0, 1, 3, 'h33,         0, 0, 0,          0, 0, 0, 3,   1, 0, 0, 1, 0,  7, 'h77,     1);
        add(0, 0, 0, 0,            0, 0, 0,          1, 3, 0, 3,   0, 0, 0, 1, 1,  3, 'h33,     1);
        add(0, 0, 0, 0,            0, 0, 0,          0, 0, 0, 3,   0, 0, 0, 1, 0,  3, 'h33,     1);
        add(0, 0, 0, 0,            0, 0, 0,          0, 0, 0, 3,   0, 0, 0, 1, 0,  3, 'h33,     1);
        add(0, 1, 0, 'hFFFFFFFF,   0, 0, 0,          0, 0, 0, 3,   1, 0, 0, 1, 0,  3, 'h33,     1);
        add(0, 0, 0, 0,            0, 0, 0,          1, 0, 0, 3,   0, 0, 0, 1, 0,  0, 0,        0);
        add(0, 0, 0, 0,            0, 0, 0,          0, 0, 0, 3,   0, 0, 0, 1, 0,  0, 0,        0);
        add(0, 0, 0, 0,            1, 3, 0,          0, 0, 0, 3,   0, 1, 0, 1, 0,  0, 0,        0);
        add(0, 0, 0, 0,            0, 0, 0,          0, 0, 0, 3,   0, 0, 0, 1, 1,  3, 0,        1);
        add(0, 0, 0, 0,            0, 0, 0,          0, 0, 0, 3,   0, 0, 0, 0, 0,  3, 0,        1);
        add(0, 1, 8, 'h88,         1, 9, 'h99,       0, 0, 0, 0,   1, 0, 0, 0, 0,  3, 0,        1);
        add(0, 0, 0, 0,            1, 9, 'h99,       0, 0, 0, 0,   0, 1, 0, 0, 1,  8, 'h88,     1);
        add(0, 0, 0, 0,            0, 0, 0,          0, 0, 0, 0,   0, 0, 0, 0, 1,  9, 'h99,     1);
        add(0, 1, 10, 'h1010,      1, 11, 'h1111,    0, 0, 0, 0,   0, 1, 0, 0, 0,  9, 'h99,     1);
        add(0, 1, 10, 'h1010,      0, 0, 0,          0, 0, 0, 0,   1, 0, 0, 0, 1,  11, 'h1111,  1);
        add(0, 0, 0, 0,            0, 0, 0,          0, 0, 0, 0,   0, 0, 0, 0, 1,  10, 'h1010,  1);
        add(0, 0, 0, 0,            0, 0, 0,          0, 0, 0, 0,   0, 0, 0, 0, 0,  10, 'h1010,  1);

        foreach (vecs[i]) begin
            vec_t v;
            v = vecs[i];
            rst = v.rs[0];
            exu_valid = v.ev[0]; exu_waddr = v.ea[4:0]; exu_wdata = v.ed;
            lsu_valid = v.lv[0]; lsu_waddr = v.la[4:0]; lsu_wdata = v.ld;
            set_en = v.se[0]; set_addr = v.sa[4:0];
            chk_addr1 = v.c1[4:0]; chk_addr2 = v.c2[4:0];
            #1;
            $display("vec %0d: exu(%0d x%0d) lsu(%0d x%0d) set(%0d x%0d)", i,
                     v.ev, v.ea, v.lv, v.la, v.se, v.sa);
            chk($sformatf("vec%0d exu_ready", i), 32'(exu_ready), v.er);
            chk($sformatf("vec%0d lsu_ready", i), 32'(lsu_ready), v.lr);
            chk($sformatf("vec%0d busy1", i), 32'(busy1), v.b1);
            chk($sformatf("vec%0d busy2", i), 32'(busy2), v.b2);
            chk($sformatf("vec%0d rf_wen", i), 32'(rf_wen), v.wen);
            if (v.cw != 0) begin
                chk($sformatf("vec%0d rf_waddr", i), 32'(rf_waddr), v.wa);
                chk($sformatf("vec%0d rf_wdata", i), rf_wdata, v.wd);
            end
            tick();
        end

        // Reset while a write is in flight; pointer was moved to LSU first.
        idle_inputs();
        set_en = 1'b1; set_addr = 5'd12; chk_addr1 = 5'd12;
        #1;
        chk("rst_seq busy before set", 32'(busy1), 32'd0);
        tick();
        idle_inputs();
        exu_valid = 1'b1; exu_waddr = 5'd12; exu_wdata = 32'hC;
        lsu_valid = 1'b1; lsu_waddr = 5'd13; lsu_wdata = 32'hD;
        chk_addr1 = 5'd12;
        #1;
        $display("rst_seq: handshake EXU x12 with LSU contending");
        chk("rst_seq exu_ready N", 32'(exu_ready), 32'd1);
        chk("rst_seq busy1 N", 32'(busy1), 32'd1);
        tick();
        exu_waddr = 5'd14; exu_wdata = 32'hE;
        rst = 1'b1;
        #1;
        $display("rst_seq: reset asserted with write in flight");
        chk("rst_seq rf_wen N+1", 32'(rf_wen), 32'd0);
        chk("rst_seq exu_ready in rst", 32'(exu_ready), 32'd0);
        chk("rst_seq lsu_ready in rst", 32'(lsu_ready), 32'd0);
        tick();
        rst = 1'b0;
        #1;
        chk("rst_seq rf_wen N+2", 32'(rf_wen), 32'd0);
        chk("rst_seq rf_waddr N+2", 32'(rf_waddr), 32'd0);
        chk("rst_seq rf_wdata N+2", rf_wdata, 32'd0);
        chk("rst_seq busy1 N+2", 32'(busy1), 32'd0);
        chk("rst_seq exu_ready N+2", 32'(exu_ready), 32'd1);
        chk("rst_seq lsu_ready N+2", 32'(lsu_ready), 32'd0);
        tick();
        idle_inputs();
        #1;
        $display("rst_seq: EXU x14 written after reset");
        chk("rst_seq rf_wen N+3", 32'(rf_wen), 32'd1);
        chk("rst_seq rf_waddr N+3", 32'(rf_waddr), 32'd14);
        chk("rst_seq rf_wdata N+3", rf_wdata, 32'hE);
        tick();

        rand_phase(600);

        idle_inputs();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule : tb_rf_wb_ctrl

// File: doc/rf_wb_ctrl.md
Name: rf_wb_ctrl

Overview:
Write-back controller for the integer register file. Shares the file's single write port between two write-back requesters, EXU (ALU results) and LSU (load data), using valid/ready handshakes and round-robin arbitration. It registers the winning write toward the register file and keeps a per-register busy scoreboard that the IDU uses for RAW hazard stalls. It sits between EXU/LSU/IDU and the register file.

Parameters:
ADDR_WIDTH, 5, register index width; 2**ADDR_WIDTH registers
DATA_WIDTH, 32, register data width

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
exu_valid  in  1  EXU write-back request
exu_ready  out  1  EXU request accepted this cycle
exu_waddr  in  ADDR_WIDTH  EXU destination register
exu_wdata  in  DATA_WIDTH  EXU result
lsu_valid  in  1  LSU write-back request
lsu_ready  out  1  LSU request accepted this cycle
lsu_waddr  in  ADDR_WIDTH  LSU destination register
lsu_wdata  in  DATA_WIDTH  LSU load data
set_en  in  1  IDU issued an instruction that writes set_addr
set_addr  in  ADDR_WIDTH  destination register of the issued instruction
chk_addr1  in  ADDR_WIDTH  IDU source register 1
chk_addr2  in  ADDR_WIDTH  IDU source register 2
busy1  out  1  chk_addr1 has a pending write
busy2  out  1  chk_addr2 has a pending write
rf_wen  out  1  register-file write enable
rf_waddr  out  ADDR_WIDTH  register-file write address
rf_wdata  out  DATA_WIDTH  register-file write data

Behaviour:
- Reset: rf_wen=0, rf_waddr=0, rf_wdata=0, all busy bits=0, round-robin pointer = EXU preferred. busy1/busy2 read 0 in the cycle after reset.
- Arbitration is combinational. Only one requester valid -> it is granted. Both valid -> the side indicated by the pointer is granted. After a contended grant, the pointer moves to the other side. An uncontended grant leaves the pointer unchanged.
- x_ready = grant to x. No grant is made when x_valid=0, so ready is never 1 for an idle requester. Requesters must hold valid, waddr and wdata stable until ready is 1.
- Handshake at cycle N (valid & ready) -> at cycle N+1: rf_wen=1, rf_waddr and rf_wdata hold the accepted values. With no handshake, rf_wen=0 the next cycle and rf_waddr/rf_wdata hold their previous values.
- Throughput is one write per cycle. Back-to-back grants are allowed. There is no output stall.
- Writes to x0: the handshake completes and rf_wen stays 0 at N+1. x0 is never busy.
- Scoreboard: one busy bit per register.
  - Set: set_en=1 and set_addr≠0 sets busy[set_addr] at the next edge.
  - Clear: busy[rf_waddr] clears at the edge ending the rf_wen=1 cycle.
  - Set and clear on the same register in the same cycle -> set wins; the bit stays 1 because the new instruction is younger.
  - Set on an already-busy register -> the bit stays 1. This is an IDU protocol violation and is flagged by a bench assertion.
- busy1 = busy[chk_addr1] and busy2 = busy[chk_addr2], read combinationally from the registered bits. There is no bypass of same-cycle set/clear, which keeps the IDU stall conservative for one cycle. chk_addr = 0 reads 0.
- Reset asserted mid-operation: the in-flight write at the output is dropped (rf_wen=0 the next cycle), all busy bits clear, and the pointer resets. Ready outputs are 0 while rst=1.

Decomposition:
- Shared package: ADDR_WIDTH/DATA_WIDTH defaults, the x0 index constant, and a requester-ID enum (EXU=0, LSU=1) used for the round-robin pointer.
- One sub-module: rf_scoreboard, holding the busy bit vector with its set/clear logic and the two read ports. Arbiter and output register stay in rf_wb_ctrl.

Test Plan:
- Single EXU write: exu_valid=1, waddr=5, wdata=0x1234 at cycle N -> exu_ready=1 at N; rf_wen=1, rf_waddr=5, rf_wdata=0x1234 at N+1; rf_wen=0 at N+2.
- Contention: both valid for 4 cycles with distinct addresses 1..4 -> grants alternate EXU, LSU, EXU, LSU starting from reset pointer; each accepted write appears on rf_* one cycle later in the same order.
- Scoreboard life: set_en with set_addr=7, chk_addr1=7 -> busy1=1 from the next cycle; LSU writes reg 7 -> busy1=0 the cycle after rf_wen=1.
- Same-cycle set/clear: reg 3 busy, rf_wen=1 to reg 3 while set_en=1 set_addr=3 -> busy[3] remains 1 afterward.
- x0 handling: EXU writes x0 data 0xFFFFFFFF -> exu_ready=1, rf_wen=0 next cycle; set_en with set_addr=0 -> busy for chk_addr=0 stays 0.
- Reset mid-flight: handshake at N, rst=1 at N+1 -> rf_wen=0 at N+1 and N+2, all busy bits 0, next contention grants EXU first.
